next_line_prefetcher: RTL and testbench
=======================================

// Module: next_line_prefetcher
// PURPOSE
//  Sequential next-line prefetcher directly upstream of the prefetch cache datapath.
//  Observes demand misses from the cache controller and fetches line (miss_line + STRIDE) from pmem.
//  Holds that line in a one-entry buffer.
//  Presents it to the cache via prefetch_rdata / prefetch_ready / pf_cline_address until the cache control acks the fill.
// PARAMETERS
//  S_OFFSET  5   log2 bytes per line; line = 2**S_OFFSET bytes = 256 bits
//  STRIDE    1   lines ahead of miss line to fetch (unsigned, >=1)
// PORTS
//  clk               in   1    clock
//  rst               in   1    synchronous active-high reset
//  miss_valid        in   1    1-cycle pulse: demand miss accepted by cache control
//  miss_address      in   32   CPU address of that miss (offset bits ignored)
//  pf_pmem_read      out  1    read request to pmem arbiter/cacheline adapter
//  pf_pmem_address   out  32   line-aligned address of request
//  pf_pmem_resp      in   1    1-cycle pulse: pf_pmem_rdata valid
//  pf_pmem_rdata     in   256  line data from pmem
//  prefetch_ready    out  1    buffer holds a valid line for the cache
//  prefetch_rdata    out  256  buffered line
//  pf_cline_address  out  32   line-aligned address of buffered line
//  pf_fill_ack       in   1    1-cycle pulse: cache consumed or discarded the buffered line
//  pf_busy           out  1    1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; buffer data, address and last_pf_line cleared; last_pf_valid=0.
//  FSM states IDLE -> READ -> FULL -> IDLE.
//  Target line = {miss_address[31:S_OFFSET] + STRIDE, S_OFFSET'b0}; 27-bit add, no modulo.
//  Top-of-memory:
//   - If the add carries out (target would wrap past 0xFFFFFFE0), the miss is ignored.
//   - No request is issued.
//  IDLE:
//   - On miss_valid with a legal target != last_pf_line (or last_pf_valid=0): latch target, set last_pf_line, go READ.
//   - A legal target equal to last_pf_line is ignored, so repeated misses do not re-fetch.
//  READ:
//   - pf_pmem_read=1, pf_pmem_address=latched target.
//   - Held high and stable every cycle until pf_pmem_resp.
//   - On pf_pmem_resp: capture rdata into buffer, deassert read the next cycle, go FULL.
//  FULL:
//   - prefetch_ready=1; prefetch_rdata / pf_cline_address stable.
//   - On pf_fill_ack: prefetch_ready drops the next cycle, go IDLE.
//  Ack outside FULL is ignored.
//  Latency:
//   - miss_valid at cycle N -> pf_pmem_read=1 at N+1.
//   - pf_pmem_resp at cycle M -> prefetch_ready=1 at M+1.
//  miss_valid in READ or FULL is dropped, with no queueing; last_pf_line is unchanged.
//  miss_valid in the same cycle as pf_fill_ack in FULL: return to IDLE; the miss is dropped.
//  rst has priority over everything, including mid-READ.
//   - Outstanding request abandoned; pf_pmem_read=0 the next cycle.
//   - The adapter shares rst and also resets.
//  pf_busy = (state != IDLE).
// TESTING
//  1. Reset with prefetch_ready forced high by prior state -> all outputs 0 the cycle after rst.
//  2. miss 0x00001234 -> pf_pmem_address=0x00001240 the next cycle; resp with data D -> ready, rdata=D, cline=0x00001240; ack -> idle.
//  3. Second miss 0x00001220 after ack (target 0x00001240 again) -> no request; miss 0x00001260 -> request 0x00001280.
//  4. miss 0xFFFFFFE4 -> no pf_pmem_read ever; STRIDE=2, miss 0xFFFFFFC0 -> no request.
//  5. miss while READ (resp delayed 10 cycles) -> pf_pmem_address held constant, read stays high, second miss dropped.
//  6. rst asserted two cycles into READ -> read low the next cycle, IDLE; late resp pulse ignored, ready stays 0.

Source files
------------

// File: rtl/next_line_prefetcher_if.sv
// Bus bundle between the next-line prefetcher, the cache controller and the pmem adapter.
// master = prefetcher side, slave = cache/pmem side.
interface next_line_prefetcher_if;
   logic         miss_valid;
   logic [31:0]  miss_address;
   logic         pf_pmem_read;
   logic [31:0]  pf_pmem_address;
   logic         pf_pmem_resp;
   logic [255:0] pf_pmem_rdata;
   logic         prefetch_ready;
   logic [255:0] prefetch_rdata;
   logic [31:0]  pf_cline_address;
   logic         pf_fill_ack;
   logic         pf_busy;

   modport master (
      input  miss_valid, miss_address, pf_pmem_resp, pf_pmem_rdata, pf_fill_ack,
      output pf_pmem_read, pf_pmem_address, prefetch_ready, prefetch_rdata, pf_cline_address,
      output pf_busy
   );

   modport slave (
      output miss_valid, miss_address, pf_pmem_resp, pf_pmem_rdata, pf_fill_ack,
      input  pf_pmem_read, pf_pmem_address, prefetch_ready, prefetch_rdata, pf_cline_address,
      input  pf_busy
   );
endinterface

// File: rtl/next_line_prefetcher.sv
// Sequential next-line prefetcher: on a demand miss, fetches line (miss_line + STRIDE) from
// pmem into a one-entry buffer and offers it to the cache until the fill is acked.
module next_line_prefetcher #(
   parameter int unsigned S_OFFSET = 5,
   parameter int unsigned STRIDE   = 1
) (
   input logic                   clk,
   input logic                   rst,
   next_line_prefetcher_if.master bus
);
   localparam int unsigned TagW = 32 - S_OFFSET;
   localparam logic [TagW:0] StrideExt = (TagW + 1)'(STRIDE);

   typedef enum logic [1:0] {StIdle, StRead, StFull} state_e;

   state_e            state_q, state_d;
   logic [31:0]       target_q, target_d;
   logic [31:0]       cline_q, cline_d;
   logic [255:0]      buf_q, buf_d;
   logic [TagW-1:0]   last_line_q, last_line_d;
   logic              last_valid_q, last_valid_d;

   logic [TagW:0]     sum;
   logic [TagW-1:0]   tag;
   logic              legal;
   logic              new_line;
   logic              unused_offset;

   // Extra sum bit is the carry out; a carry means the target would wrap past the top.
   assign sum           = {1'b0, bus.miss_address[31:S_OFFSET]} + StrideExt;
   assign tag           = sum[TagW-1:0];
   assign legal         = ~sum[TagW];
   assign new_line      = ~last_valid_q || (tag != last_line_q);
   assign unused_offset = ^bus.miss_address[S_OFFSET-1:0];

   always_comb begin
      state_d      = state_q;
      target_d     = target_q;
      cline_d      = cline_q;
      buf_d        = buf_q;
      last_line_d  = last_line_q;
      last_valid_d = last_valid_q;
      case (state_q)
         StIdle: begin
            if (bus.miss_valid && legal && new_line) begin
               target_d     = {tag, {S_OFFSET{1'b0}}};
               last_line_d  = tag;
               last_valid_d = 1'b1;
               state_d      = StRead;
            end
         end
         StRead: begin
            if (bus.pf_pmem_resp) begin
               buf_d   = bus.pf_pmem_rdata;
               cline_d = target_q;
               state_d = StFull;
            end
         end
         StFull: begin
            // A miss arriving with the ack is dropped, not queued.
            if (bus.pf_fill_ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         target_q     <= '0;
         cline_q      <= '0;
         buf_q        <= '0;
         last_line_q  <= '0;
         last_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         cline_q      <= cline_d;
         buf_q        <= buf_d;
         last_line_q  <= last_line_d;
         last_valid_q <= last_valid_d;
      end
   end

   assign bus.pf_pmem_read     = (state_q == StRead);
   assign bus.pf_pmem_address  = target_q;
   assign bus.prefetch_ready   = (state_q == StFull);
   assign bus.prefetch_rdata   = buf_q;
   assign bus.pf_cline_address = cline_q;
   assign bus.pf_busy          = (state_q != StIdle);
endmodule

// File: tb/tb_next_line_prefetcher.sv
// Self-checking bench for next_line_prefetcher: directed vector table, hand sequences for
// multi-cycle corners, and a randomized run against a line-arithmetic reference model.
module tb_next_line_prefetcher;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   next_line_prefetcher_if bus ();
   next_line_prefetcher_if bus2 ();

   next_line_prefetcher #(.S_OFFSET(5), .STRIDE(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   next_line_prefetcher #(.S_OFFSET(5), .STRIDE(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic         mv;
      logic [31:0]  ma;
      logic         resp;
      logic [255:0] rd;
      logic         ack;
      logic         e_read;
      logic [31:0]  e_addr;
      logic         e_ready;
      logic [31:0]  e_cline;
      logic [255:0] e_data;
      logic         e_busy;
      logic         all;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic mv, input logic [31:0] ma,
                               input logic resp, input logic [255:0] rd, input logic ack,
                               input logic e_read, input logic [31:0] e_addr,
                               input logic e_ready, input logic [31:0] e_cline,
                               input logic [255:0] e_data, input logic e_busy,
                               input logic all);
      vec_t v;
      v.rst = r; v.mv = mv; v.ma = ma; v.resp = resp; v.rd = rd; v.ack = ack;
      v.e_read = e_read; v.e_addr = e_addr; v.e_ready = e_ready; v.e_cline = e_cline;
      v.e_data = e_data; v.e_busy = e_busy; v.all = all;
      return v;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs on the main DUT, then sample 1ns after the edge.
   task automatic cyc(input logic r, input logic mv, input logic [31:0] ma, input logic resp,
                      input logic [255:0] rd, input logic ack);
      rst              = r;
      bus.miss_valid   = mv;
      bus.miss_address = ma;
      bus.pf_pmem_resp = resp;
      bus.pf_pmem_rdata = rd;
      bus.pf_fill_ack  = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'h0, 1'b0, '0, 1'b0);
   endtask

   // Reference model: request/buffer flags plus line arithmetic on wide integers.
   bit           m_pending;
   bit           m_have;
   longint       m_req;
   longint       m_cline;
   logic [255:0] m_data;
   bit           m_seen;
   longint       m_last;

   task automatic model_clock(input logic r, input logic mv, input logic [31:0] ma,
                              input logic resp, input logic [255:0] rd, input logic ack);
      longint t;
      if (r) begin
         m_pending = 0; m_have = 0; m_req = 0; m_cline = 0; m_data = '0;
         m_seen = 0; m_last = 0;
      end else if (m_pending) begin
         if (resp) begin
            m_pending = 0; m_have = 1; m_data = rd; m_cline = m_req;
         end
      end else if (m_have) begin
         if (ack) m_have = 0;
      end else if (mv) begin
         t = ((longint'(ma) / 32) + 1) * 32;
         if (t <= 64'h0000_0000_FFFF_FFFF && (!m_seen || t != m_last)) begin
            m_pending = 1; m_req = t; m_last = t; m_seen = 1;
         end
      end
   endtask

   logic [255:0] d1, d2, d3, d4, rnd;

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus.miss_valid = 0; bus.miss_address = 0; bus.pf_pmem_resp = 0;
      bus.pf_pmem_rdata = '0; bus.pf_fill_ack = 0;
      bus2.miss_valid = 0; bus2.miss_address = 0; bus2.pf_pmem_resp = 0;
      bus2.pf_pmem_rdata = '0; bus2.pf_fill_ack = 0;
      d1 = {8{32'hA5A5_0001}};
      d2 = {8{32'h5A5A_0002}};
      d3 = {8{32'hC3C3_0003}};
      d4 = {8{32'h1234_0004}};
      @(posedge clk);
      #1;

      // Directed table: basic fetch, repeat suppression, reset from FULL, top-of-memory.
      vecs.push_back(mk(1, 0, 32'h0,        0, '0, 0, 0, 32'h0,    0, 32'h0,    '0, 0, 1));
      vecs.push_back(mk(0, 1, 32'h00001234, 0, '0, 0, 1, 32'h1240, 0, 32'h0,    '0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, '0, 0, 1, 32'h1240, 0, 32'h0,    '0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, d1, 0, 0, 32'h0,    1, 32'h1240, d1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, '0, 0, 0, 32'h0,    1, 32'h1240, d1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, '0, 1, 0, 32'h0,    0, 32'h0,    '0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h00001220, 0, '0, 0, 0, 32'h0,    0, 32'h0,    '0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h00001260, 0, '0, 0, 1, 32'h1280, 0, 32'h0,    '0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, d2, 0, 0, 32'h0,    1, 32'h1280, d2, 1, 0));
      vecs.push_back(mk(1, 0, 32'h0,        0, '0, 0, 0, 32'h0,    0, 32'h0,    '0, 0, 1));
      vecs.push_back(mk(0, 1, 32'hFFFFFFE4, 0, '0, 0, 0, 32'h0,    0, 32'h0,    '0, 0, 0));
      vecs.push_back(mk(0, 1, 32'hFFFFFFE0, 0, '0, 0, 0, 32'h0,    0, 32'h0,    '0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h00001220, 0, '0, 0, 1, 32'h1240, 0, 32'h0,    '0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, '0, 1, 1, 32'h1240, 0, 32'h0,    '0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, d3, 0, 0, 32'h0,    1, 32'h1240, d3, 1, 0));
      vecs.push_back(mk(0, 1, 32'h00005000, 0, '0, 1, 0, 32'h0,    0, 32'h0,    '0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, '0, 0, 0, 32'h0,    0, 32'h0,    '0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, '0, 1, 0, 32'h0,    0, 32'h0,    '0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].rst, vecs[i].mv, vecs[i].ma, vecs[i].resp, vecs[i].rd, vecs[i].ack);
         chk($sformatf("vec%0d read", i), bus.pf_pmem_read, vecs[i].e_read);
         chk($sformatf("vec%0d ready", i), bus.prefetch_ready, vecs[i].e_ready);
         chk($sformatf("vec%0d busy", i), bus.pf_busy, vecs[i].e_busy);
         if (vecs[i].all || vecs[i].e_read)
            chk($sformatf("vec%0d addr", i), bus.pf_pmem_address, vecs[i].e_addr);
         if (vecs[i].all || vecs[i].e_ready) begin
            chk($sformatf("vec%0d cline", i), bus.pf_cline_address, vecs[i].e_cline);
            chk($sformatf("vec%0d rdata", i), bus.prefetch_rdata, vecs[i].e_data);
         end
      end

      // Miss during a long READ: request held stable, second miss dropped without queueing.
      cyc(1, 0, 0, 0, '0, 0);
      cyc(0, 1, 32'h00002000, 0, '0, 0);
      chk("hold read0", bus.pf_pmem_read, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cyc(0, (i == 3), 32'h00003000, 0, '0, 0);
         chk($sformatf("hold read%0d", i + 1), bus.pf_pmem_read, 1'b1);
         chk($sformatf("hold addr%0d", i + 1), bus.pf_pmem_address, 32'h00002020);
      end
      cyc(0, 0, 0, 1, d4, 0);
      chk("hold ready", bus.prefetch_ready, 1'b1);
      chk("hold cline", bus.pf_cline_address, 32'h00002020);
      chk("hold rdata", bus.prefetch_rdata, d4);
      cyc(0, 0, 0, 0, '0, 1);
      chk("hold ack", bus.prefetch_ready, 1'b0);
      idle();
      chk("hold no queued", bus.pf_pmem_read, 1'b0);
      cyc(0, 1, 32'h00003000, 0, '0, 0);
      chk("hold refetch read", bus.pf_pmem_read, 1'b1);
      chk("hold refetch addr", bus.pf_pmem_address, 32'h00003020);

      // Reset two cycles into READ, then a stale response.
      cyc(1, 0, 0, 0, '0, 0);
      cyc(0, 1, 32'h00004000, 0, '0, 0);
      idle();
      cyc(1, 0, 0, 0, '0, 0);
      chk("rstread read", bus.pf_pmem_read, 1'b0);
      chk("rstread busy", bus.pf_busy, 1'b0);
      cyc(0, 0, 0, 1, d1, 0);
      chk("late resp ready", bus.prefetch_ready, 1'b0);
      idle();
      chk("late resp ready2", bus.prefetch_ready, 1'b0);
      chk("late resp busy", bus.pf_busy, 1'b0);

      // STRIDE=2 instance: carry past top ignored, the last legal line still fetched.
      bus2.miss_valid = 1; bus2.miss_address = 32'hFFFFFFC0;
      idle();
      bus2.miss_valid = 0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("s2 top read%0d", i), bus2.pf_pmem_read, 1'b0);
         idle();
      end
      bus2.miss_valid = 1; bus2.miss_address = 32'hFFFFFFA0;
      idle();
      bus2.miss_valid = 0;
      chk("s2 last read", bus2.pf_pmem_read, 1'b1);
      chk("s2 last addr", bus2.pf_pmem_address, 32'hFFFFFFE0);

      // Randomized run against the reference model.
      cyc(1, 0, 0, 0, '0, 0);
      model_clock(1, 0, 0, 0, '0, 0);
      for (int n = 0; n < 1500; n++) begin
         logic        r, mv, rs, ak;
         logic [31:0] ma;
         r  = ($urandom_range(0, 255) == 0);
         mv = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 3) == 0);
         ak = ($urandom_range(0, 3) == 0);
         ma = (($urandom_range(0, 1) == 0) ? 32'h00001000 : 32'hFFFFFF00)
              + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
         for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom();
         cyc(r, mv, ma, rs, rnd, ak);
         model_clock(r, mv, ma, rs, rnd, ak);
         chk($sformatf("rnd%0d read", n), bus.pf_pmem_read, m_pending);
         chk($sformatf("rnd%0d ready", n), bus.prefetch_ready, m_have);
         chk($sformatf("rnd%0d busy", n), bus.pf_busy, m_pending | m_have);
         if (m_pending)
            chk($sformatf("rnd%0d addr", n), bus.pf_pmem_address, m_req[31:0]);
         if (m_have) begin
            chk($sformatf("rnd%0d cline", n), bus.pf_cline_address, m_cline[31:0]);
            chk($sformatf("rnd%0d rdata", n), bus.prefetch_rdata, m_data);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
